// File: rtl/path_player.sv
// path_player: replays a solved maze path from the move queue on its own
// position tracker and reports whether the walk lands on the goal in-grid.
module path_player #(
    parameter logic [3:0] START_X     = 4'd0,
    parameter logic [3:0] START_Y     = 4'd0,
    parameter logic [3:0] GOAL_X      = 4'd15,
    parameter logic [3:0] GOAL_Y      = 4'd15,
    parameter int         HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       q_empty,
    input  logic [1:0] move,
    output logic       q_rd,
    output logic [3:0] pos_x,
    output logic [3:0] pos_y,
    output logic       step_valid,
    output logic [7:0] step_count,
    output logic       busy,
    output logic       done,
    output logic       error
);
    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, FETCH, WAIT, APPLY, HOLD, FINISH} state_t;

    state_t        state_q, state_d;
    logic [3:0]    x_q, x_d, y_q, y_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [CW-1:0] hold_q, hold_d;
    logic [1:0]    mv_q, mv_d;
    logic          sv_q, sv_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic          on_x, inc, oob, off_goal;
    logic [3:0]    x_nx, y_nx;

    // move[1]^move[0] selects the x axis; move[0]=0 means increment
    assign on_x     = mv_q[1] ^ mv_q[0];
    assign inc      = ~mv_q[0];
    assign oob      = on_x ? (inc ? x_q == 4'd15 : x_q == 4'd0) : (inc ? y_q == 4'd15 : y_q == 4'd0);
    assign x_nx     = on_x ? (inc ? x_q + 4'd1 : x_q - 4'd1) : x_q;
    assign y_nx     = on_x ? y_q : (inc ? y_q + 4'd1 : y_q - 4'd1);
    assign off_goal = (x_q != GOAL_X) || (y_q != GOAL_Y);

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        mv_d    = mv_q;
        sv_d    = 1'b0;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;
        q_rd    = 1'b0;
        case (state_q)
            IDLE, FINISH: if (start) begin
                x_d     = START_X;
                y_d     = START_Y;
                cnt_d   = 8'd0;
                done_d  = 1'b0;
                err_d   = 1'b0;
                busy_d  = 1'b1;
                state_d = FETCH;
            end
            FETCH: begin
                q_rd    = ~q_empty;
                state_d = q_empty ? FINISH : WAIT;
            end
            WAIT: begin
                mv_d    = move;
                state_d = APPLY;
            end
            APPLY: if (oob) begin
                state_d = FINISH;
            end else begin
                x_d     = x_nx;
                y_d     = y_nx;
                cnt_d   = cnt_q + {7'd0, cnt_q != 8'hFF};
                sv_d    = 1'b1;
                hold_d  = '0;
                state_d = HOLD;
            end
            HOLD: begin
                hold_d  = hold_q + 1'b1;
                state_d = (hold_q == HOLD_LAST) ? FETCH : HOLD;
            end
            default: state_d = IDLE;
        endcase
        // pos is unchanged on every path into FINISH, so off_goal sees the final cell
        if (state_d == FINISH && state_q != FINISH) begin
            busy_d = 1'b0;
            done_d = 1'b1;
            err_d  = err_q | off_goal | (state_q == APPLY);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= START_X;
            y_q     <= START_Y;
            cnt_q   <= 8'd0;
            hold_q  <= '0;
            mv_q    <= 2'b00;
            sv_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            mv_q    <= mv_d;
            sv_q    <= sv_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign pos_x      = x_q;
    assign pos_y      = y_q;
    assign step_count = cnt_q;
    assign step_valid = sv_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = err_q;
endmodule

// File: tb/tb_path_player.sv
// tb_path_player: directed and random replays of path_player against a
// coordinate-walk reference model with a simple queue model feeding moves.
module tb_path_player;
    logic       clk = 1'b0, rst = 1'b1, start = 1'b0, start2 = 1'b0;
    logic       q_empty;
    logic [1:0] move = 2'b00;
    logic       q_rd, step_valid, busy, done, error;
    logic [3:0] pos_x, pos_y;
    logic [7:0] step_count;
    logic       q_rd2, step_valid2, busy2, done2, error2;
    logic [3:0] pos_x2, pos_y2;
    logic [7:0] step_count2;

    int checks = 0, failures = 0;
    logic [1:0] mem [0:1023];
    int   wr_n = 0, rd_idx = 0;
    logic rd_pend = 1'b0;
    int   cyc = 0, rd_cnt = 0, sv_cnt = 0, prot_err = 0, stab_err = 0, rd2_cnt = 0;
    int   sv_t [0:1023];
    logic [3:0] sv_x [0:1023];
    logic [3:0] sv_y [0:1023];
    logic p_busy = 1'b0;
    logic [15:0] p_val = 16'd0;
    int   ex [0:255];
    int   ey [0:255];
    int   m_steps, m_reads, m_x, m_y;
    logic m_err;

    assign q_empty = (rd_idx == wr_n);
    always #5 clk = ~clk;

    path_player dut (
        .clk(clk), .rst(rst), .start(start), .q_empty(q_empty), .move(move),
        .q_rd(q_rd), .pos_x(pos_x), .pos_y(pos_y), .step_valid(step_valid),
        .step_count(step_count), .busy(busy), .done(done), .error(error)
    );

    path_player #(.START_X(4'd3), .START_Y(4'd3), .GOAL_X(4'd3), .GOAL_Y(4'd3)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .q_empty(1'b1), .move(2'b00),
        .q_rd(q_rd2), .pos_x(pos_x2), .pos_y(pos_y2), .step_valid(step_valid2),
        .step_count(step_count2), .busy(busy2), .done(done2), .error(error2)
    );

    // queue pops on the edge that ends the q_rd cycle; data is valid the next cycle
    always @(posedge clk) begin
        if (rd_pend) begin
            move   <= mem[rd_idx];
            rd_idx <= rd_idx + 1;
        end
    end

    always @(negedge clk) begin
        cyc     <= cyc + 1;
        rd_pend <= q_rd;
        if (q_rd) rd_cnt <= rd_cnt + 1;
        if (q_rd && (q_empty || rd_pend)) prot_err <= prot_err + 1;
        if (q_rd2) rd2_cnt <= rd2_cnt + 1;
        if (step_valid) begin
            sv_t[sv_cnt] <= cyc;
            sv_x[sv_cnt] <= pos_x;
            sv_y[sv_cnt] <= pos_y;
            sv_cnt       <= sv_cnt + 1;
        end
        if (!rst && p_busy && !step_valid && {pos_x, pos_y, step_count} != p_val) stab_err <= stab_err + 1;
        p_busy <= busy;
        p_val  <= {pos_x, pos_y, step_count};
    end

    function automatic void model(input int base, input int n);
        int dx [4] = '{0, -1, 1, 0};
        int dy [4] = '{1, 0, 0, -1};
        int x = 0, y = 0, nx, ny;
        m_steps = 0;
        m_reads = 0;
        m_err   = 1'b0;
        for (int i = 0; i < n; i++) begin
            m_reads++;
            nx = x + dx[mem[base+i]];
            ny = y + dy[mem[base+i]];
            if (nx < 0 || nx > 15 || ny < 0 || ny > 15) begin
                m_err = 1'b1;
                break;
            end
            x = nx;
            y = ny;
            ex[m_steps] = x;
            ey[m_steps] = y;
            m_steps++;
        end
        m_x   = x;
        m_y   = y;
        m_err = m_err || x != 15 || y != 15;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [1:0] m);
        mem[wr_n] = m;
        wr_n++;
    endtask

    task automatic pulse_start;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done;
        int n = 0;
        while (!done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        #1;
        chk("done_reached", 32'(done), 1);
    endtask

    task automatic check_run(input string tag, input int base, input int n, input int rd0, input int sv0);
        model(base, n);
        chk({tag, "_reads"}, rd_cnt - rd0, m_reads);
        chk({tag, "_steps"}, sv_cnt - sv0, m_steps);
        for (int i = 0; i < m_steps && sv0 + i < sv_cnt; i++) begin
            chk({tag, "_step_x"}, 32'(sv_x[sv0+i]), ex[i]);
            chk({tag, "_step_y"}, 32'(sv_y[sv0+i]), ey[i]);
            if (i > 0) chk({tag, "_step_gap"}, sv_t[sv0+i] - sv_t[sv0+i-1], 7);
        end
        chk({tag, "_pos_x"}, 32'(pos_x), m_x);
        chk({tag, "_pos_y"}, 32'(pos_y), m_y);
        chk({tag, "_step_count"}, 32'(step_count), m_steps);
        chk({tag, "_error"}, 32'(error), 32'(m_err));
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_protocol"}, prot_err, 0);
        chk({tag, "_stability"}, stab_err, 0);
    endtask

    initial begin
        int base, rd0, sv0, n, snap;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_pos_x", 32'(pos_x), 0);
        chk("rst_pos_y", 32'(pos_y), 0);
        chk("rst_count", 32'(step_count), 0);
        chk("rst_flags", {28'd0, busy, done, error, step_valid}, 0);
        chk("rst_q_rd", 32'(q_rd), 0);

        // full diagonal-ish path to the goal, with a stray start mid-replay
        base = wr_n;
        for (int i = 0; i < 15; i++) load(2'b10);
        for (int i = 0; i < 15; i++) load(2'b00);
        rd0 = rd_cnt; sv0 = sv_cnt;
        pulse_start;
        repeat (12) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done;
        check_run("goal", base, 30, rd0, sv0);
        chk("goal_done", 32'(done), 1);

        // first move leaves the grid; restart from FINISH reloads the start cell
        base = wr_n;
        load(2'b01);
        rd0 = rd_cnt; sv0 = sv_cnt;
        pulse_start;
        chk("restart_pos", {24'd0, pos_x, pos_y}, 0);
        chk("restart_flags", {29'd0, busy, done, error}, 3'b100);
        wait_done;
        check_run("oob", base, 1, rd0, sv0);

        base = wr_n;
        load(2'b10); load(2'b10); load(2'b00);
        rd0 = rd_cnt; sv0 = sv_cnt;
        pulse_start;
        wait_done;
        check_run("short", base, 3, rd0, sv0);

        for (int r = 0; r < 6; r++) begin
            wr_n = rd_idx;
            base = wr_n;
            n = (r == 0) ? 0 : $urandom_range(1, 32);
            for (int i = 0; i < n; i++)
                load(($urandom_range(0, 9) < 7) ? ($urandom_range(0, 1) ? 2'b10 : 2'b00) : 2'($urandom_range(0, 3)));
            rd0 = rd_cnt; sv0 = sv_cnt;
            pulse_start;
            wait_done;
            check_run("rand", base, n, rd0, sv0);
        end

        // asynchronous reset while holding a stepped position
        wr_n = rd_idx;
        for (int i = 0; i < 5; i++) load(2'b10);
        pulse_start;
        n = 0;
        while (!step_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("hold_reached", 32'(step_valid), 1);
        #1 rst = 1'b1;
        #1;
        chk("arst_pos", {24'd0, pos_x, pos_y}, 0);
        chk("arst_flags", {29'd0, busy, done, q_rd}, 0);
        snap = rd_cnt;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        chk("arst_no_rd", rd_cnt, snap);
        chk("arst_idle", {30'd0, busy, done}, 0);
        wr_n = rd_idx;

        // empty queue with start == goal
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        @(negedge clk);
        #1;
        chk("sg_done", 32'(done2), 1);
        chk("sg_error", 32'(error2), 0);
        chk("sg_busy", 32'(busy2), 0);
        chk("sg_pos", {24'd0, pos_x2, pos_y2}, 8'h33);
        chk("sg_steps", {23'd0, step_count2, step_valid2}, 0);
        chk("sg_no_rd", rd2_cnt, 0);
        chk("protocol_final", prot_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
